// File: rtl/gsim_mem_server_pkg.sv
// Shared constants for the GSIM matrix-memory server: back-pressure modes and LFSR definition.
package gsim_mem_pkg;

  localparam int RRDY_ALWAYS   = 0;
  localparam int RRDY_PERIODIC = 1;
  localparam int RRDY_LFSR     = 2;

  localparam int LFSR_W = 16;
  // Taps 16,14,13,11 counted from 1 at the LSB end map to bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gsim_mem_server_if.sv
// Request/data/preload bundle between the GSIM core (master) and the memory server (slave).
interface gsim_mem_server_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10
);
  logic              i_rreq;
  logic [ADDR_W-1:0] i_addr;
  logic              o_rrdy;
  logic [DATA_W-1:0] o_dout;
  logic              o_dout_vld;
  logic              i_wen;
  logic [ADDR_W-1:0] i_waddr;
  logic [DATA_W-1:0] i_wdata;
  logic [15:0]       o_rd_cnt;

  modport master (
    output i_rreq, i_addr, i_wen, i_waddr, i_wdata,
    input  o_rrdy, o_dout, o_dout_vld, o_rd_cnt
  );

  modport slave (
    input  i_rreq, i_addr, i_wen, i_waddr, i_wdata,
    output o_rrdy, o_dout, o_dout_vld, o_rd_cnt
  );
endinterface

// File: rtl/gsim_mem_server_rrdy_gen.sv
// Registered read-ready pattern generator: always ready, one stall per period, or LFSR-driven.
module gsim_rrdy_gen
  import gsim_mem_pkg::*;
#(
  parameter int                RRDY_MODE    = RRDY_ALWAYS,
  parameter int                STALL_PERIOD = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic o_rrdy
);
  localparam int              CNT_W    = $clog2(STALL_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic              rrdy_nxt;

  // Ready is computed from next-state so the registered output lines up with cnt/lfsr.
  always_comb begin
    cnt_nxt  = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    lfsr_nxt = lfsr_next(lfsr);
    case (RRDY_MODE)
      RRDY_PERIODIC: rrdy_nxt = (cnt_nxt != CNT_LAST);
      RRDY_LFSR:     rrdy_nxt = (lfsr_nxt[1:0] != 2'b00);
      default:       rrdy_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      o_rrdy <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      lfsr   <= lfsr_nxt;
      o_rrdy <= rrdy_nxt;
    end
  end

endmodule

// File: rtl/gsim_mem_server.sv
// Matrix-memory responder: preloadable row store, LATENCY-deep read pipeline, self-generated
// back-pressure and an accepted-read counter.
module gsim_mem_server
  import gsim_mem_pkg::*;
#(
  parameter int                DATA_W       = 256,
  parameter int                ADDR_W       = 10,
  parameter int                LATENCY      = 1,
  parameter int                RRDY_MODE    = RRDY_ALWAYS,
  parameter int                STALL_PERIOD = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
  input logic               i_clk,
  input logic               i_reset,
  gsim_mem_server_if.slave  mem_if
);
  logic [DATA_W-1:0]              mem [2**ADDR_W];
  logic [LATENCY-1:0]             pipe_vld;
  logic [LATENCY-1:0][DATA_W-1:0] pipe_dat;
  logic [15:0]                    rd_cnt;
  logic                           rrdy;
  logic                           accept;

  gsim_rrdy_gen #(
    .RRDY_MODE    (RRDY_MODE),
    .STALL_PERIOD (STALL_PERIOD),
    .LFSR_SEED    (LFSR_SEED)
  ) u_rrdy_gen (
    .clk    (i_clk),
    .reset  (i_reset),
    .o_rrdy (rrdy)
  );

  assign accept = mem_if.i_rreq & rrdy;

  // Contents survive reset so a preloaded matrix outlives a solver restart.
  always_ff @(posedge i_clk) begin
    if (mem_if.i_wen) mem[mem_if.i_waddr] <= mem_if.i_wdata;
  end

  // Data is zeroed alongside its valid bit, keeping o_dout at 0 between pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pipe_vld <= '0;
      pipe_dat <= '0;
      rd_cnt   <= '0;
    end else begin
      pipe_vld[0] <= accept;
      pipe_dat[0] <= accept ? mem[mem_if.i_addr] : '0;
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      if (accept) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign mem_if.o_rrdy     = rrdy;
  assign mem_if.o_dout     = pipe_dat[LATENCY-1];
  assign mem_if.o_dout_vld = pipe_vld[LATENCY-1];
  assign mem_if.o_rd_cnt   = rd_cnt;

endmodule

// File: tb/tb_gsim_mem_server.sv
// Directed bench for gsim_mem_server: four instances cover latency 1/4 and all back-pressure modes.
module tb_gsim_mem_server;
  import gsim_mem_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gsim_mem_server_if #(.DATA_W(256), .ADDR_W(10)) if_a ();
  gsim_mem_server_if #(.DATA_W(256), .ADDR_W(10)) if_b ();
  gsim_mem_server_if #(.DATA_W(256), .ADDR_W(10)) if_c ();
  gsim_mem_server_if #(.DATA_W(256), .ADDR_W(10)) if_d ();

  gsim_mem_server #(.DATA_W(256), .ADDR_W(10), .LATENCY(1), .RRDY_MODE(0))
    u_a (.i_clk(clk), .i_reset(reset), .mem_if(if_a));
  gsim_mem_server #(.DATA_W(256), .ADDR_W(10), .LATENCY(4), .RRDY_MODE(0))
    u_b (.i_clk(clk), .i_reset(reset), .mem_if(if_b));
  gsim_mem_server #(.DATA_W(256), .ADDR_W(10), .LATENCY(1), .RRDY_MODE(1), .STALL_PERIOD(4))
    u_c (.i_clk(clk), .i_reset(reset), .mem_if(if_c));
  gsim_mem_server #(.DATA_W(256), .ADDR_W(10), .LATENCY(1), .RRDY_MODE(2), .LFSR_SEED(16'hACE1))
    u_d (.i_clk(clk), .i_reset(reset), .mem_if(if_d));

  function automatic logic [255:0] pat(input int a);
    logic [7:0] b;
    b   = a[7:0];
    pat = {32{b}};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [15:0] m;
  logic        exp_v;
  logic        exp_r;
  logic        r;
  int          n;
  int          acc;

  initial begin
    if_a.i_rreq = 0; if_a.i_addr = '0; if_a.i_wen = 0; if_a.i_waddr = '0; if_a.i_wdata = '0;
    if_b.i_rreq = 0; if_b.i_addr = '0; if_b.i_wen = 0; if_b.i_waddr = '0; if_b.i_wdata = '0;
    if_c.i_rreq = 0; if_c.i_addr = '0; if_c.i_wen = 0; if_c.i_waddr = '0; if_c.i_wdata = '0;
    if_d.i_rreq = 0; if_d.i_addr = '0; if_d.i_wen = 0; if_d.i_waddr = '0; if_d.i_wdata = '0;
    tick();
    do_reset();

    // Reset values
    check("rst_a_rrdy", if_a.o_rrdy, 1);
    check("rst_a_dout", if_a.o_dout, 0);
    check("rst_a_vld", if_a.o_dout_vld, 0);
    check("rst_a_cnt", if_a.o_rd_cnt, 0);
    check("rst_b_rrdy", if_b.o_rrdy, 1);
    check("rst_c_rrdy", if_c.o_rrdy, 1);
    check("rst_d_rrdy", if_d.o_rrdy, 1);

    // Preload rows 0..15 in every instance
    for (int a = 0; a < 16; a++) begin
      if_a.i_wen = 1; if_a.i_waddr = 10'(a); if_a.i_wdata = pat(a);
      if_b.i_wen = 1; if_b.i_waddr = 10'(a); if_b.i_wdata = pat(a);
      if_c.i_wen = 1; if_c.i_waddr = 10'(a); if_c.i_wdata = pat(a);
      if_d.i_wen = 1; if_d.i_waddr = 10'(a); if_d.i_wdata = pat(a);
      tick();
    end
    if_a.i_wen = 0; if_b.i_wen = 0; if_c.i_wen = 0; if_d.i_wen = 0;

    // Mode 0, latency 1: 16 back-to-back reads
    for (int k = 0; k <= 16; k++) begin
      check("a_vld", if_a.o_dout_vld, (k >= 1) ? 1 : 0);
      check("a_dout", if_a.o_dout, (k >= 1) ? pat(k - 1) : '0);
      if_a.i_rreq = (k < 16);
      if_a.i_addr = 10'(k);
      tick();
    end
    check("a_vld_end", if_a.o_dout_vld, 0);
    check("a_rd_cnt", if_a.o_rd_cnt, 16);

    // Latency 4: single read of address 5
    if_b.i_rreq = 1; if_b.i_addr = 10'd5;
    tick();
    if_b.i_rreq = 0;
    for (int k = 1; k <= 3; k++) begin
      check("b_single_vld_lo", if_b.o_dout_vld, 0);
      check("b_single_dout_lo", if_b.o_dout, 0);
      tick();
    end
    check("b_single_vld", if_b.o_dout_vld, 1);
    check("b_single_dout", if_b.o_dout, pat(5));
    tick();
    check("b_single_vld_off", if_b.o_dout_vld, 0);

    // Latency 4: burst of 8
    for (int k = 0; k <= 12; k++) begin
      exp_v = (k >= 4) && (k < 12);
      check("b_burst_vld", if_b.o_dout_vld, exp_v);
      check("b_burst_dout", if_b.o_dout, exp_v ? pat(k - 4) : '0);
      if_b.i_rreq = (k < 8);
      if_b.i_addr = 10'(k);
      tick();
    end

    // Same-cycle write and read on address 7
    if_a.i_wen = 1; if_a.i_waddr = 10'd7; if_a.i_wdata = 256'h11;
    tick();
    if_a.i_wdata = 256'h22; if_a.i_rreq = 1; if_a.i_addr = 10'd7;
    tick();
    if_a.i_wen = 0;
    check("a_rw_vld", if_a.o_dout_vld, 1);
    check("a_rw_old", if_a.o_dout, 256'h11);
    tick();
    if_a.i_rreq = 0;
    check("a_rw_new", if_a.o_dout, 256'h22);
    tick();

    // Mode 1, period 4: request held for 12 cycles
    do_reset();
    n = 0;
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) check("c_rrdy", if_c.o_rrdy, ((j % 4) != 3) ? 1 : 0);
      if (j >= 1) begin
        exp_v = ((j - 1) % 4) != 3;
        check("c_vld", if_c.o_dout_vld, exp_v);
        check("c_dout", if_c.o_dout, exp_v ? pat(j - 1) : '0);
      end
      if (if_c.o_dout_vld) n++;
      if_c.i_rreq = (j < 12);
      if_c.i_addr = 10'(j);
      tick();
    end
    check("c_rd_cnt", if_c.o_rd_cnt, 9);
    check("c_vld_count", 256'(n), 9);

    // Mode 2: LFSR stall pattern over 1000 cycles
    do_reset();
    m   = 16'hACE1;
    acc = 0;
    for (int j = 0; j < 1000; j++) begin
      exp_r = (m[1:0] != 2'b00);
      check("d_rrdy", if_d.o_rrdy, exp_r);
      r = 1'($urandom_range(0, 1));
      if_d.i_rreq = r;
      if_d.i_addr = 10'($urandom_range(0, 15));
      if (r && exp_r) acc++;
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      tick();
    end
    if_d.i_rreq = 0;
    check("d_rd_cnt", if_d.o_rd_cnt, 256'(acc[15:0]));

    // Reset with three reads in flight at latency 4
    for (int j = 0; j < 3; j++) begin
      if_b.i_rreq = 1; if_b.i_addr = 10'(j + 1);
      tick();
    end
    if_b.i_rreq = 0;
    check("b_cnt_pre", if_b.o_rd_cnt, 3);
    reset = 1'b1;
    tick();
    check("b_rst_vld", if_b.o_dout_vld, 0);
    check("b_rst_dout", if_b.o_dout, 0);
    check("b_rst_cnt", if_b.o_rd_cnt, 0);
    check("b_rst_rrdy", if_b.o_rrdy, 1);
    reset = 1'b0;
    n = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (if_b.o_dout_vld) n++;
    end
    check("b_no_ghost", 256'(n), 0);
    if_b.i_rreq = 1; if_b.i_addr = 10'd3;
    tick();
    if_b.i_rreq = 0;
    tick(); tick(); tick();
    check("b_keep_vld", if_b.o_dout_vld, 1);
    check("b_keep_dout", if_b.o_dout, pat(3));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gsim_mem_server.md
# gsim_mem_server

Parametrised matrix-memory responder for the GSIM solver environment, and the successor to the fixed 256-bit, 1-cycle matrix memory model. It holds the coefficient/vector rows, accepts read requests through a ready/request handshake, and returns data after a configurable pipeline latency. It also generates its own `o_rrdy` back-pressure pattern (always-ready, periodic stall, or pseudo-random), so the GSIM core can be stressed without bench-side stall logic. It sits between the GSIM core's `o_mem_*` port and the bench, and can also be synthesised as an on-chip buffer.

## Interface
- `DATA_W`, default 256: row width in bits.
- `ADDR_W`, default 10: address width; depth = 2^ADDR_W.
- `LATENCY`, default 1: cycles from acceptance to data valid; legal range 1..4.
- `RRDY_MODE`, default 0: back-pressure mode. 0 = always ready, 1 = periodic stall, 2 = LFSR.
- `STALL_PERIOD`, default 4: in mode 1, `o_rrdy` is low 1 cycle out of every STALL_PERIOD; legal range ≥2.
- `LFSR_SEED`, default 16'hACE1: reset value of the LFSR; must be non-zero.

Ports:
- `i_clk`, in, 1: single clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_rreq`, in, 1: read request.
- `i_addr`, in, ADDR_W: read address, sampled with `i_rreq`.
- `o_rrdy`, out, 1: server can accept a request this cycle.
- `o_dout`, out, DATA_W: read data; all zeros whenever `o_dout_vld` = 0.
- `o_dout_vld`, out, 1: `o_dout` is valid this cycle.
- `i_wen`, in, 1: preload write enable, active high.
- `i_waddr`, in, ADDR_W: preload address.
- `i_wdata`, in, DATA_W: preload data.
- `o_rd_cnt`, out, 16: number of accepted reads; wraps modulo 2^16.

## Operation
- **Acceptance:** a read is accepted in cycle C when `i_rreq` and `o_rrdy` are both 1 at the rising edge. If `i_rreq` is high while `o_rrdy` is low, the request is ignored and is not queued; the requester must hold or re-issue it.
- **Read path:** on acceptance, `mem[i_addr]` is captured into a shift pipeline of depth LATENCY, with one valid bit per stage.
- **Data return:** exactly one `o_dout_vld` pulse is produced per accepted read, in order. Back-to-back accepts give back-to-back valids.
- **Writes:**
  - When `i_wen` = 1, `mem[i_waddr]` = `i_wdata` at the edge.
  - If a write and an accepted read hit the same address in the same cycle, the read returns the old data.
  - Writes are always accepted and are not gated by `o_rrdy`.
- **Back-pressure modes:** `o_rrdy` is a register.
  - Mode 0: `o_rrdy` is held at 1.
  - Mode 1: a counter `cnt` runs 0..STALL_PERIOD-1 and wraps. `o_rrdy` is 0 only in the cycle where `cnt` = STALL_PERIOD-1.
  - Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every cycle. `o_rrdy` = (lfsr[1:0] != 2'b00), which gives about 75 % ready.
- **Read counter:** `o_rd_cnt` increments by 1 per accepted read and wraps from 16'hFFFF to 0.
- **Reset:**
  - The pipeline valid bits, `o_dout`/`o_dout_vld`, `cnt` and `o_rd_cnt` are cleared.
  - The LFSR is reloaded with LFSR_SEED.
  - Memory contents are not reset.
  - Reads in flight when reset asserts are discarded and never appear.

## Timing
- Reset values: `o_rrdy` = 1, `o_dout` = 0, `o_dout_vld` = 0, `o_rd_cnt` = 0.
- A read accepted in cycle C has `o_dout_vld` = 1 in cycle C+LATENCY, for exactly one cycle. With LATENCY = 1 the data appears in the cycle immediately after acceptance.
- `o_rrdy` depends only on internal state and never on `i_rreq` (no combinational path).
- The first cycle after reset deasserts always has `o_rrdy` = 1, in every mode.
- The stall pattern advances every cycle, independent of traffic.
- Sustained throughput is one accepted read per cycle whenever `o_rrdy` = 1.

## Structure
- Package `gsim_mem_pkg` holds:
  - Mode constants `RRDY_ALWAYS`, `RRDY_PERIODIC`, `RRDY_LFSR`.
  - LFSR width and tap mask.
  - Default LFSR seed.
- Sub-module `gsim_rrdy_gen`: holds the mode counter and LFSR, with parameters RRDY_MODE, STALL_PERIOD and LFSR_SEED, and outputs the registered `o_rrdy`.
- The top level holds the memory array, the read pipeline and the read counter.

## Test plan
- **Mode 0, LATENCY = 1:** preload addresses 0..15 with 256'h{addr repeated}, read 0..15 back-to-back. Expect 16 consecutive `o_dout_vld` pulses, data in order, each pulse one cycle after its accept, and `o_rd_cnt` = 16.
- **LATENCY = 4:** issue a single read of address 5. Expect `o_dout` = 0 and `o_dout_vld` = 0 for 3 cycles, then `mem[5]` for one cycle. A burst of 8 reads gives 8 contiguous valids starting 4 cycles after the first accept.
- **Mode 1, STALL_PERIOD = 4, `i_rreq` held high for 12 cycles:** expect `o_rrdy` pattern 1,1,1,0 repeated, exactly 9 accepts and 9 valids, and no data for the stalled cycles.
- **Mode 2, seed 16'hACE1:** over 1000 cycles, the `o_rrdy` sequence matches the reference LFSR model bit-for-bit, and `o_rd_cnt` equals the number of cycles with `i_rreq` & `o_rrdy` = 1.
- **Same-cycle write and read to address 7:** old value 'h11, write 'h22 together with an accepted read. The read returns 'h11; a following read returns 'h22.
- **Reset mid-operation:** assert `i_reset` with 3 reads in flight at LATENCY = 4. No valid pulse appears afterwards, and all outputs take their reset values the cycle after the reset edge. `o_rd_cnt` = 0 and memory still holds its preloaded data.
